// File: rtl/sigmoid_lut_regfile.sv
// -----------------------------------------------------------------------------
// sigmoid_lut_regfile
//
// Register file that holds the sigmoid activation lookup table for the neuron
// datapath. The table can be filled two ways:
//   * random single-entry writes (write_en/address_in/data_in), ignored while a
//     bulk load is in progress or when the address is beyond the table;
//   * a streamed bulk load (load_start, then DEPTH beats on load_valid/
//     load_ready) that fills entries 0..DEPTH-1 in order.
// lut_valid is raised only when a bulk load has delivered all DEPTH beats.
// NUM_READ independent read ports return the stored entry one cycle after the
// address is presented. Same-cycle writes are not forwarded, so a read returns
// the value held before that write.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears the table too)
//   write_en    random write strobe
//   address_in  random write address
//   data_in     random write data
//   wr_reject   one-cycle pulse: the previous cycle's random write was dropped
//   load_start  begin, or restart, a bulk load at address 0
//   load_valid  load_data carries a beat
//   load_data   bulk-load beat data
//   load_ready  high while a bulk load is accepting beats
//   lut_valid   a complete bulk load has finished
//   rd_addr     packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data     packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   addr_err    bit i set when port i's address was beyond the table
// -----------------------------------------------------------------------------
module sigmoid_lut_regfile #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           write_en,
    input  logic [ADDR_WIDTH-1:0]          address_in,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic                           wr_reject,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [DATA_WIDTH-1:0]          load_data,
    output logic                           load_ready,
    output logic                           lut_valid,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            addr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter and address comparisons use one extra bit so that a table
    // filling the whole address space does not wrap before the last beat.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_t                  state_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic                    lut_valid_reg;
    logic                    wr_reject_reg;
    logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];

    logic in_load;
    logic wr_addr_ok;
    logic wr_accept;
    logic load_fire;

    assign in_load    = (state_reg == LOAD);
    assign wr_addr_ok = ({1'b0, address_in} < DEPTH_EXT);
    assign wr_accept  = write_en & wr_addr_ok & ~in_load;
    // A restart in the same cycle as a beat wins; the beat is thrown away.
    assign load_fire  = in_load & load_valid & ~load_start;

    assign load_ready = in_load;
    assign lut_valid  = lut_valid_reg;
    assign wr_reject  = wr_reject_reg;

    // -------------------------------------------------------------------------
    // Bulk-load sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            lut_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_start) begin
                        state_reg     <= LOAD;
                        count_reg     <= '0;
                        lut_valid_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        count_reg <= '0;
                    end else if (load_valid) begin
                        if (count_reg == LAST_BEAT) begin
                            state_reg     <= DONE;
                            lut_valid_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state_reg     <= LOAD;
                        count_reg     <= '0;
                        lut_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    count_reg     <= '0;
                    lut_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Dropped random writes are reported one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_reject_reg <= 1'b0;
        end else begin
            wr_reject_reg <= write_en & ~(wr_addr_ok & ~in_load);
        end
    end

    // -------------------------------------------------------------------------
    // Table storage. Load beats and random writes never coincide because
    // random writes are refused while loading.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                mem_reg[i] <= '0;
            end else if (load_fire && (count_reg == (ADDR_WIDTH+1)'(i))) begin
                mem_reg[i] <= load_data;
            end else if (wr_accept && (address_in == ADDR_WIDTH'(i))) begin
                mem_reg[i] <= data_in;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: registered, no write bypass, out-of-range reads return zero.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  addr_ok;
        logic [DATA_WIDTH-1:0] data_reg;
        logic                  err_reg;

        assign addr    = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign addr_ok = ({1'b0, addr} < DEPTH_EXT);

        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= '0;
                err_reg  <= 1'b0;
            end else begin
                err_reg  <= ~addr_ok;
                data_reg <= addr_ok ? mem_reg[addr] : '0;
            end
        end

        assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
        assign addr_err[gi]                         = err_reg;
    end

endmodule

// File: tb/tb_sigmoid_lut_regfile.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_lut_regfile
//
// Two instances: u_dut with the default 32-entry table and u_small with a
// 20-entry table (out-of-range addresses inside the 5-bit address space).
// Stimulus pushes hand-computed expectations tagged with the cycle at which
// they must hold; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_sigmoid_lut_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       rst;
    logic       write_en;
    logic [4:0] address_in;
    logic [3:0] data_in;
    logic       wr_reject;
    logic       load_start;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       lut_valid;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic [1:0] addr_err;

    // 20-entry instance
    logic       b_write_en;
    logic [4:0] b_address_in;
    logic [3:0] b_data_in;
    logic       b_wr_reject;
    logic       b_load_start;
    logic       b_load_valid;
    logic [3:0] b_load_data;
    logic       b_load_ready;
    logic       b_lut_valid;
    logic [4:0] b_rd_addr;
    logic [3:0] b_rd_data;
    logic [0:0] b_addr_err;

    sigmoid_lut_regfile #(
        .DATA_WIDTH(4), .DEPTH(32), .ADDR_WIDTH(5), .NUM_READ(2)
    ) u_dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .address_in(address_in), .data_in(data_in),
        .wr_reject(wr_reject),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .lut_valid(lut_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .addr_err(addr_err)
    );

    sigmoid_lut_regfile #(
        .DATA_WIDTH(4), .DEPTH(20), .ADDR_WIDTH(5), .NUM_READ(1)
    ) u_small (
        .clk(clk), .rst(rst),
        .write_en(b_write_en), .address_in(b_address_in), .data_in(b_data_in),
        .wr_reject(b_wr_reject),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_ready(b_load_ready), .lut_valid(b_lut_valid),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .addr_err(b_addr_err)
    );

    typedef enum int {
        S_RD0, S_RD1, S_ERR0, S_ERR1, S_REJ, S_LUTV, S_LRDY,
        S_BRD, S_BERR, S_BREJ, S_BLUTV, S_BLRDY
    } sel_t;

    typedef struct {
        string      name;
        sel_t       sel;
        int         due;
        logic [3:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;
    logic rej_exp;
    logic b_rej_exp;

    always begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [3:0] actual(sel_t s);
        case (s)
            S_RD0:   return rd_data[3:0];
            S_RD1:   return rd_data[7:4];
            S_ERR0:  return {3'b000, addr_err[0]};
            S_ERR1:  return {3'b000, addr_err[1]};
            S_REJ:   return {3'b000, wr_reject};
            S_LUTV:  return {3'b000, lut_valid};
            S_LRDY:  return {3'b000, load_ready};
            S_BRD:   return b_rd_data;
            S_BERR:  return {3'b000, b_addr_err[0]};
            S_BREJ:  return {3'b000, b_wr_reject};
            S_BLUTV: return {3'b000, b_lut_valid};
            S_BLRDY: return {3'b000, b_load_ready};
            default: return 4'hx;
        endcase
    endfunction

    // Value that must be visible during the current cycle.
    task automatic expect_now(string n, sel_t s, logic [3:0] v);
        sb.push_back('{name: n, sel: s, due: cyc, val: v});
    endtask

    // Value that must be visible after the coming clock edge.
    task automatic expect_next(string n, sel_t s, logic [3:0] v);
        sb.push_back('{name: n, sel: s, due: cyc + 1, val: v});
    endtask

    // Advance one clock; wr_reject of both instances is checked every cycle.
    task automatic tick();
        expect_next("wr_reject", S_REJ, {3'b000, rej_exp});
        expect_next("b_wr_reject", S_BREJ, {3'b000, b_rej_exp});
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always begin
        @(negedge clk);
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due <= cyc) begin
                logic [3:0] got;
                got   = actual(sb[k].sel);
                tests = tests + 1;
                if (sb[k].due < cyc || got !== sb[k].val) begin
                    fails = fails + 1;
                    $display("FAIL %s: got %0h required %0h (cycle %0d)",
                             sb[k].name, got, sb[k].val, cyc);
                end else begin
                    $display("[TB] ok %s = %0h (cycle %0d)", sb[k].name, got, cyc);
                end
                sb.delete(k);
            end
        end
        if (done) begin
            if (sb.size() != 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL leftover: got %0d unchecked entries required 0", sb.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; write_en = 1'b0; address_in = '0; data_in = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; rd_addr = '0;
        b_write_en = 1'b0; b_address_in = '0; b_data_in = '0;
        b_load_start = 1'b0; b_load_valid = 1'b0; b_load_data = '0; b_rd_addr = '0;
        rej_exp = 1'b0; b_rej_exp = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        expect_now("rst_rd0", S_RD0, 4'h0);
        expect_now("rst_rd1", S_RD1, 4'h0);
        expect_now("rst_err0", S_ERR0, 4'h0);
        expect_now("rst_lutv", S_LUTV, 4'h0);
        expect_now("rst_lrdy", S_LRDY, 4'h0);
        expect_now("rst_b_rd", S_BRD, 4'h0);
        expect_now("rst_b_lutv", S_BLUTV, 4'h0);
        expect_now("rst_b_lrdy", S_BLRDY, 4'h0);

        // Random write then read back
        write_en = 1'b1; address_in = 5'd7; data_in = 4'hA;
        tick();
        write_en = 1'b0; rd_addr[4:0] = 5'd7;
        expect_next("t1_rd0", S_RD0, 4'hA);
        expect_next("t1_err0", S_ERR0, 4'h0);
        tick();

        // Bulk load with load_valid toggling; random write during load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b0;
            expect_now($sformatf("t2_ready_%0d", i), S_LRDY, 4'h1);
            expect_now($sformatf("t2_lutv_%0d", i), S_LUTV, 4'h0);
            tick();
            load_valid = 1'b1; load_data = 4'(i);
            if (i == 3) begin
                write_en = 1'b1; address_in = 5'd3; data_in = 4'hF; rej_exp = 1'b1;
            end
            expect_now($sformatf("t2_ready_b%0d", i), S_LRDY, 4'h1);
            expect_now($sformatf("t2_lutv_b%0d", i), S_LUTV, 4'h0);
            tick();
            write_en = 1'b0; rej_exp = 1'b0;
        end
        load_valid = 1'b0;
        expect_now("t2_lutv_done", S_LUTV, 4'h1);
        expect_now("t2_ready_done", S_LRDY, 4'h0);
        for (int i = 0; i < 32; i += 2) begin
            rd_addr = {5'(i + 1), 5'(i)};
            expect_next($sformatf("t2_entry%0d", i), S_RD0, 4'(i));
            expect_next($sformatf("t2_entry%0d", i + 1), S_RD1, 4'(i + 1));
            tick();
        end

        // Same-cycle write and read: old value first, new value next
        write_en = 1'b1; address_in = 5'd9; data_in = 4'h5; rd_addr = {5'd9, 5'd0};
        expect_next("t5_old", S_RD1, 4'h9);
        tick();
        write_en = 1'b0;
        expect_next("t5_new", S_RD1, 4'h5);
        tick();
        expect_now("t5_lutv_kept", S_LUTV, 4'h1);

        // 20-entry instance: boundary and out-of-range handling
        b_write_en = 1'b1; b_address_in = 5'd9; b_data_in = 4'h2;
        tick();
        b_address_in = 5'd19; b_data_in = 4'h7;
        tick();
        b_address_in = 5'd25; b_data_in = 4'hF; b_rej_exp = 1'b1; b_rd_addr = 5'd19;
        expect_next("t4_rd19", S_BRD, 4'h7);
        expect_next("t4_err19", S_BERR, 4'h0);
        tick();
        b_write_en = 1'b0; b_rej_exp = 1'b0; b_rd_addr = 5'd25;
        expect_next("t4_rd25", S_BRD, 4'h0);
        expect_next("t4_err25", S_BERR, 4'h1);
        tick();
        b_rd_addr = 5'd20;
        expect_next("t4_rd20", S_BRD, 4'h0);
        expect_next("t4_err20", S_BERR, 4'h1);
        tick();
        b_rd_addr = 5'd9;
        expect_next("t4_rd9_kept", S_BRD, 4'h2);
        tick();

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0; load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            load_data = 4'hC;
            tick();
        end
        load_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_now("t6_lutv_rst", S_LUTV, 4'h0);
        expect_now("t6_lrdy_rst", S_LRDY, 4'h0);
        rd_addr = {5'd5, 5'd0}; b_rd_addr = 5'd19;
        expect_next("t6_rd_e0", S_RD0, 4'h0);
        expect_next("t6_rd_e5", S_RD1, 4'h0);
        expect_next("t6_b_rd19", S_BRD, 4'h0);
        tick();
        rd_addr = {5'd31, 5'd9};
        expect_next("t6_rd_e9", S_RD0, 4'h0);
        expect_next("t6_rd_e31", S_RD1, 4'h0);
        expect_now("t6_lrdy_idle", S_LRDY, 4'h0);
        tick();

        // Restart at beat 5 of a new load, then fill with reversed data
        load_start = 1'b1;
        tick();
        load_start = 1'b0; load_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_data = 4'(i + 1);
            tick();
        end
        load_start = 1'b1; load_data = 4'hE;
        tick();
        load_start = 1'b0;
        for (int j = 0; j < 32; j++) begin
            load_data = 4'(31 - j);
            expect_now($sformatf("t6_lutv_%0d", j), S_LUTV, 4'h0);
            expect_now($sformatf("t6_lrdy_%0d", j), S_LRDY, 4'h1);
            tick();
        end
        load_valid = 1'b0;
        expect_now("t6_lutv_done", S_LUTV, 4'h1);
        expect_now("t6_lrdy_done", S_LRDY, 4'h0);
        rd_addr = {5'd5, 5'd0};
        expect_next("t6_re_e0", S_RD0, 4'hF);
        expect_next("t6_re_e5", S_RD1, 4'hA);
        tick();
        rd_addr = {5'd31, 5'd1};
        expect_next("t6_re_e1", S_RD0, 4'hE);
        expect_next("t6_re_e31", S_RD1, 4'h0);
        tick();
        rd_addr = '0;
        tick();
        tick();
        done = 1'b1;
    end

endmodule
